// File: rtl/fwd_pkg.sv
// Shared types and constants for the forwarding scoreboard: entry layout,
// stage indices and the register-file forward-select code.
package fwd_pkg;

    localparam int FWD_AW    = 5;
    localparam int FWD_DEPTH = 3;
    localparam int FWD_LW    = $clog2(FWD_DEPTH + 1);

    localparam int STG_EX  = 1;
    localparam int STG_MEM = 2;
    localparam int STG_WB  = FWD_DEPTH;

    localparam int FWD_RF = 0;

    // One in-flight register write; rdy is the stage whose output holds the result.
    typedef struct packed {
        logic              vld;
        logic [FWD_AW-1:0] waddr;
        logic [FWD_LW-1:0] rdy;
    } sb_entry_t;

endpackage

// File: rtl/fwd_scoreboard_if.sv
// ID-stage request / stall / forward-select bundle between the decode logic
// and the forwarding scoreboard.
interface fwd_scoreboard_if #(
    parameter int NUM_RD = 2,
    parameter int AW     = 5,
    parameter int FW     = 2,
    parameter int LW     = 2
);
    logic                   id_valid;
    logic [NUM_RD*AW-1:0]   id_rs;
    logic [NUM_RD-1:0]      id_rd_en;
    logic                   id_regwr;
    logic [AW-1:0]          id_wr_addr;
    logic [LW-1:0]          id_lat;
    logic                   id_flush;
    logic                   stall;
    logic [NUM_RD*FW-1:0]   ex_fwd_sel;
    logic [15:0]            stall_cnt;

    modport master (
        output id_valid, id_rs, id_rd_en, id_regwr, id_wr_addr, id_lat, id_flush,
        input  stall, ex_fwd_sel, stall_cnt
    );

    modport slave (
        input  id_valid, id_rs, id_rd_en, id_regwr, id_wr_addr, id_lat, id_flush,
        output stall, ex_fwd_sel, stall_cnt
    );
endinterface

// File: rtl/fwd_port_check.sv
// Combinational scoreboard search for one read port: finds the youngest
// matching in-flight write and decides register file, forward, or stall.
module fwd_port_check
    import fwd_pkg::*;
#(
    parameter int DEPTH     = FWD_DEPTH,
    parameter int AW        = FWD_AW,
    parameter int FW        = 2,
    parameter int WB_BYPASS = 0
) (
    input  sb_entry_t        ent [1:DEPTH],
    input  logic             id_valid,
    input  logic             rd_en,
    input  logic [AW-1:0]    rs,
    output logic [FW-1:0]    sel,
    output logic             need_stall
);

    logic active;

    assign active = id_valid & rd_en & (rs != '0);

    // Scan oldest to youngest so the lowest matching stage overwrites the rest.
    always_comb begin
        sel        = FW'(FWD_RF);
        need_stall = 1'b0;
        if (active) begin
            for (int j = DEPTH; j >= 1; j--) begin
                if (ent[j].vld && (ent[j].waddr == rs)) begin
                    if (j < int'(ent[j].rdy)) begin
                        sel        = FW'(FWD_RF);
                        need_stall = 1'b1;
                    end else if ((WB_BYPASS != 0) && (j == DEPTH)) begin
                        sel        = FW'(FWD_RF);
                        need_stall = 1'b0;
                    end else begin
                        sel        = FW'(j);
                        need_stall = 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/fwd_scoreboard.sv
// Forwarding-select and stall unit between ID and EX: tracks in-flight
// register writes per stage and registers per-port forward selects for EX.
module fwd_scoreboard
    import fwd_pkg::*;
#(
    parameter int NUM_RD    = 2,
    parameter int DEPTH     = FWD_DEPTH,
    parameter int AW        = FWD_AW,
    parameter int FW        = 2,
    parameter int WB_BYPASS = 0
) (
    input  logic              clk,
    input  logic              reset,
    fwd_scoreboard_if.slave   bus
);

    sb_entry_t                ent_reg [1:DEPTH];
    sb_entry_t                ent_next;
    logic [NUM_RD-1:0]        port_stall;
    logic [NUM_RD*FW-1:0]     sel_next;
    logic [NUM_RD*FW-1:0]     ex_fwd_sel_reg;
    logic [15:0]              stall_cnt_reg;
    logic                     stall_int;
    logic                     issue;

    generate
        for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_port
            fwd_port_check #(
                .DEPTH     (DEPTH),
                .AW        (AW),
                .FW        (FW),
                .WB_BYPASS (WB_BYPASS)
            ) u_check (
                .ent        (ent_reg),
                .id_valid   (bus.id_valid),
                .rd_en      (bus.id_rd_en[gi]),
                .rs         (bus.id_rs[gi*AW +: AW]),
                .sel        (sel_next[gi*FW +: FW]),
                .need_stall (port_stall[gi])
            );
        end
    endgenerate

    // A squashed instruction never stalls and never enters the scoreboard.
    assign stall_int = (|port_stall) & ~bus.id_flush;
    assign issue     = bus.id_valid & bus.id_regwr & (bus.id_wr_addr != '0)
                     & ~stall_int & ~bus.id_flush;

    always_comb begin
        ent_next = '0;
        if (issue) begin
            ent_next.vld   = 1'b1;
            ent_next.waddr = bus.id_wr_addr;
            ent_next.rdy   = bus.id_lat;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int j = 1; j <= DEPTH; j++) begin
                ent_reg[j] <= '0;
            end
        end else begin
            ent_reg[STG_EX] <= ent_next;
            for (int j = 2; j <= DEPTH; j++) begin
                ent_reg[j] <= ent_reg[j-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_fwd_sel_reg <= '0;
            stall_cnt_reg  <= '0;
        end else begin
            ex_fwd_sel_reg <= stall_int ? '0 : sel_next;
            if (stall_int && (stall_cnt_reg != 16'hFFFF)) begin
                stall_cnt_reg <= stall_cnt_reg + 16'd1;
            end
        end
    end

    assign bus.stall      = stall_int;
    assign bus.ex_fwd_sel = ex_fwd_sel_reg;
    assign bus.stall_cnt  = stall_cnt_reg;

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Directed bench for fwd_scoreboard: two instances (WB_BYPASS=0 and 1) share
// the same ID-stage stimulus; expected values are hand-computed per vector.
module tb_fwd_scoreboard;

    localparam int NUM_RD = 2;
    localparam int AW     = 5;
    localparam int FW     = 2;
    localparam int DEPTH  = 3;
    localparam int LW     = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic                 id_valid;
    logic [NUM_RD*AW-1:0] id_rs;
    logic [NUM_RD-1:0]    id_rd_en;
    logic                 id_regwr;
    logic [AW-1:0]        id_wr_addr;
    logic [LW-1:0]        id_lat;
    logic                 id_flush;

    fwd_scoreboard_if #(.NUM_RD(NUM_RD), .AW(AW), .FW(FW), .LW(LW)) bus0 ();
    fwd_scoreboard_if #(.NUM_RD(NUM_RD), .AW(AW), .FW(FW), .LW(LW)) bus1 ();

    assign bus0.id_valid   = id_valid;
    assign bus0.id_rs      = id_rs;
    assign bus0.id_rd_en   = id_rd_en;
    assign bus0.id_regwr   = id_regwr;
    assign bus0.id_wr_addr = id_wr_addr;
    assign bus0.id_lat     = id_lat;
    assign bus0.id_flush   = id_flush;
    assign bus1.id_valid   = id_valid;
    assign bus1.id_rs      = id_rs;
    assign bus1.id_rd_en   = id_rd_en;
    assign bus1.id_regwr   = id_regwr;
    assign bus1.id_wr_addr = id_wr_addr;
    assign bus1.id_lat     = id_lat;
    assign bus1.id_flush   = id_flush;

    fwd_scoreboard #(.NUM_RD(NUM_RD), .DEPTH(DEPTH), .AW(AW), .FW(FW), .WB_BYPASS(0)) dut0 (
        .clk(clk), .reset(reset), .bus(bus0)
    );
    fwd_scoreboard #(.NUM_RD(NUM_RD), .DEPTH(DEPTH), .AW(AW), .FW(FW), .WB_BYPASS(1)) dut1 (
        .clk(clk), .reset(reset), .bus(bus1)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [AW-1:0] rs1, input logic [AW-1:0] rs0,
                         input logic [1:0] rd_en, input logic wr, input logic [AW-1:0] waddr,
                         input logic [LW-1:0] lat, input logic flush);
        id_valid   = v;
        id_rs      = {rs1, rs0};
        id_rd_en   = rd_en;
        id_regwr   = wr;
        id_wr_addr = waddr;
        id_lat     = lat;
        id_flush   = flush;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 5'd0, 2'b00, 1'b0, 5'd0, 2'd1, 1'b0);
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        idle();
        do_reset();
        check("reset_stall", 32'(bus0.stall), 32'd0);
        check("reset_sel", 32'(bus0.ex_fwd_sel), 32'd0);
        check("reset_cnt", 32'(bus0.stall_cnt), 32'd0);

        // ALU back-to-back: add $3 then reader of $3 on port 0
        drive(1'b1, 5'd0, 5'd0, 2'b00, 1'b1, 5'd3, 2'd1, 1'b0);
        step();
        drive(1'b1, 5'd0, 5'd3, 2'b01, 1'b1, 5'd7, 2'd1, 1'b0);
        @(negedge clk);
        check("alu_stall", 32'(bus0.stall), 32'd0);
        step();
        check("alu_sel", 32'(bus0.ex_fwd_sel), 32'h1);

        // Load-use: lw $5 (lat 2) then reader of $5 on port 1
        do_reset();
        drive(1'b1, 5'd0, 5'd0, 2'b00, 1'b1, 5'd5, 2'd2, 1'b0);
        step();
        drive(1'b1, 5'd5, 5'd0, 2'b10, 1'b1, 5'd8, 2'd1, 1'b0);
        @(negedge clk);
        check("lu_stall_1", 32'(bus0.stall), 32'd1);
        step();
        check("lu_sel_bubble", 32'(bus0.ex_fwd_sel), 32'h0);
        check("lu_cnt", 32'(bus0.stall_cnt), 32'd1);
        @(negedge clk);
        check("lu_stall_2", 32'(bus0.stall), 32'd0);
        step();
        check("lu_sel", 32'(bus0.ex_fwd_sel), 32'h8);
        check("lu_cnt_final", 32'(bus0.stall_cnt), 32'd1);

        // Youngest wins: $4 at e[3] and e[1]
        do_reset();
        drive(1'b1, 5'd0, 5'd0, 2'b00, 1'b1, 5'd4, 2'd1, 1'b0);
        step();
        drive(1'b1, 5'd0, 5'd0, 2'b00, 1'b1, 5'd10, 2'd1, 1'b0);
        step();
        drive(1'b1, 5'd0, 5'd0, 2'b00, 1'b1, 5'd4, 2'd1, 1'b0);
        step();
        drive(1'b1, 5'd0, 5'd4, 2'b01, 1'b0, 5'd0, 2'd1, 1'b0);
        @(negedge clk);
        check("young_stall", 32'(bus0.stall), 32'd0);
        step();
        check("young_sel", 32'(bus0.ex_fwd_sel), 32'h1);

        // WB-stage match with and without write-first register file
        do_reset();
        drive(1'b1, 5'd0, 5'd0, 2'b00, 1'b1, 5'd11, 2'd1, 1'b0);
        step();
        idle();
        step();
        step();
        drive(1'b1, 5'd0, 5'd11, 2'b01, 1'b0, 5'd0, 2'd1, 1'b0);
        @(negedge clk);
        check("wb_stall_nobyp", 32'(bus0.stall), 32'd0);
        check("wb_stall_byp", 32'(bus1.stall), 32'd0);
        step();
        check("wb_sel_nobyp", 32'(bus0.ex_fwd_sel), 32'h3);
        check("wb_sel_byp", 32'(bus1.ex_fwd_sel), 32'h0);

        // $0 is never tracked
        do_reset();
        drive(1'b1, 5'd0, 5'd0, 2'b00, 1'b1, 5'd0, 2'd1, 1'b0);
        step();
        drive(1'b1, 5'd0, 5'd0, 2'b11, 1'b0, 5'd0, 2'd1, 1'b0);
        @(negedge clk);
        check("r0_stall", 32'(bus0.stall), 32'd0);
        step();
        check("r0_sel", 32'(bus0.ex_fwd_sel), 32'h0);

        // Flushed reader of a load result: no stall, and its write becomes a bubble
        do_reset();
        drive(1'b1, 5'd0, 5'd0, 2'b00, 1'b1, 5'd6, 2'd2, 1'b0);
        step();
        drive(1'b1, 5'd0, 5'd6, 2'b01, 1'b1, 5'd12, 2'd1, 1'b1);
        @(negedge clk);
        check("flush_stall", 32'(bus0.stall), 32'd0);
        step();
        drive(1'b1, 5'd12, 5'd6, 2'b11, 1'b0, 5'd0, 2'd1, 1'b0);
        @(negedge clk);
        check("flush_next_stall", 32'(bus0.stall), 32'd0);
        step();
        check("flush_bubble_sel", 32'(bus0.ex_fwd_sel), 32'h2);
        check("flush_cnt", 32'(bus0.stall_cnt), 32'd0);

        // One producer feeding both ports, then an instruction reading its own destination
        do_reset();
        drive(1'b1, 5'd0, 5'd0, 2'b00, 1'b1, 5'd13, 2'd1, 1'b0);
        step();
        drive(1'b1, 5'd13, 5'd13, 2'b11, 1'b0, 5'd0, 2'd1, 1'b0);
        step();
        check("both_ports_sel", 32'(bus0.ex_fwd_sel), 32'h5);
        drive(1'b1, 5'd0, 5'd14, 2'b01, 1'b1, 5'd14, 2'd1, 1'b0);
        @(negedge clk);
        check("own_dest_stall", 32'(bus0.stall), 32'd0);
        step();
        check("own_dest_sel", 32'(bus0.ex_fwd_sel), 32'h0);
        drive(1'b1, 5'd0, 5'd14, 2'b01, 1'b0, 5'd0, 2'd1, 1'b0);
        step();
        check("after_own_sel", 32'(bus0.ex_fwd_sel), 32'h1);

        // Reset asserted in the middle of a two-cycle long-latency stall
        do_reset();
        drive(1'b1, 5'd0, 5'd0, 2'b00, 1'b1, 5'd5, 2'd3, 1'b0);
        step();
        drive(1'b1, 5'd0, 5'd5, 2'b01, 1'b0, 5'd0, 2'd1, 1'b0);
        @(negedge clk);
        check("rst_mid_stall_1", 32'(bus0.stall), 32'd1);
        step();
        check("rst_mid_cnt", 32'(bus0.stall_cnt), 32'd1);
        @(negedge clk);
        check("rst_mid_stall_2", 32'(bus0.stall), 32'd1);
        reset = 1'b1;
        step();
        check("rst_after_stall", 32'(bus0.stall), 32'd0);
        check("rst_after_sel", 32'(bus0.ex_fwd_sel), 32'h0);
        check("rst_after_cnt", 32'(bus0.stall_cnt), 32'd0);
        reset = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fwd_scoreboard.md
Name: fwd_scoreboard

Overview:
- Parametrised successor to the pipeline forwarding unit: one block does both forwarding-select generation and load-use/long-latency stall detection.
- Holds a scoreboard of in-flight register writes, one entry per post-ID stage (EX..WB), with a per-entry result-ready stage.
- For each of NUM_RD read ports in ID it decides one of three outcomes: read the register file, forward from a stage, or stall.
- Forward selects are registered so they line up with EX. Sits between the ID and EX stages of the pipeline.

Parameters:
- NUM_RD, 2, number of source-operand read ports checked per instruction (rs, rt, optionally jr/sw data).
- DEPTH, 3, tracked stages after ID (1=EX, 2=MEM, ..., DEPTH=WB).
- AW, 5, register address width. Register 0 is hard-wired zero and never tracked.
- FW, 2, forward-select width; must be at least clog2(DEPTH+1).
- WB_BYPASS, 0, 1 = register file is write-first, so WB-stage matches need no forwarding.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- id_valid  in  1  ID holds a real instruction.
- id_rs  in  NUM_RD*AW  packed source addresses; port p is bits [p*AW +: AW].
- id_rd_en  in  NUM_RD  port p actually reads its register.
- id_regwr  in  1  ID instruction writes a register.
- id_wr_addr  in  AW  destination address.
- id_lat  in  clog2(DEPTH+1)  stage (1..DEPTH) whose output holds the result: 1=ALU, 2=load.
- id_flush  in  1  squash the ID instruction (branch/jump taken).
- stall  out  1  combinational; hold PC and IF/ID, inject a bubble into EX.
- ex_fwd_sel  out  NUM_RD*FW  registered per-port select used in EX. 0 = register file; k = value produced by the instruction that was in stage k.
- stall_cnt  out  16  saturating count of stall cycles.

Behaviour:
- State: entries e[1..DEPTH], each holding {vld, waddr, rdy}.
- Every cycle all entries advance: e[j+1] <= e[j], and e[DEPTH] retires.
- e[1] loads {1, id_wr_addr, id_lat} when id_valid & id_regwr & id_wr_addr!=0 & !stall & !id_flush. Otherwise e[1] loads a bubble (vld=0).
- Match for port p: id_rd_en[p] & id_rs[p]!=0 & id_valid. Search for the youngest (lowest j) valid entry with waddr==id_rs[p]. Only the youngest counts; older matches are ignored.
- Outcome for port p:
  - No match: sel_p = 0.
  - Match at j with j >= rdy: sel_p = j.
  - Match at j with j < rdy: port needs a stall.
  - Match at j=DEPTH with WB_BYPASS=1: sel_p = 0.
- stall = OR of all port stalls, and is forced 0 when id_flush=1 (a squashed instruction never stalls).
- ex_fwd_sel <= stall ? 0 : {sel_p}. Latency is 1 cycle from ID decision to EX use.
- Load-use example: producer with rdy=2 is at e[1] while the consumer is in ID. The result is 1 cycle stall. The next cycle the producer is at e[2], and the consumer gets sel=2.
- One producer feeding both ports: both selects equal.
- An instruction reading its own destination register matches only older entries, never itself.
- stall_cnt increments on each stall cycle and saturates at 0xFFFF.
- Reset (synchronous, high): all vld=0, ex_fwd_sel=0, stall_cnt=0. stall is 0 during reset because no entries are valid.
- Reset asserted mid-stall clears the scoreboard, so stall drops the cycle after reset.
- Any valid match to register 0 is impossible by construction.

Decomposition:
- Package fwd_pkg holds:
  - The scoreboard entry struct {vld, waddr, rdy}.
  - The stage index constants STG_EX=1, STG_MEM=2, STG_WB=DEPTH.
  - The forward-select encoding constant FWD_RF=0.
- One sub-module, fwd_port_check: a combinational search of the entry array for a single port, returning {sel, need_stall}. It is instantiated NUM_RD times with a generate loop.
- The top level holds the shift register, the stall OR, the output register and the counter.

Test Plan:
- ALU back-to-back: issue add $3 (lat 1), then sub reads $3 on port 0. Required: stall=0; the cycle after, ex_fwd_sel[port0]=1.
- Load-use: issue lw $5 (lat 2), then add reads $5 on port 1. Required: stall=1 for exactly 1 cycle, stall_cnt=1, then ex_fwd_sel[port1]=2.
- Youngest wins: writes to $4 at e[3] and e[1] (lat 1), consumer reads $4. Required: sel=1, not 3.
- WB match with WB_BYPASS=0: required sel=3. Rerun with WB_BYPASS=1: required sel=0.
- $0 and flush:
  - add $0 then a read of $0: required sel=0, stall=0.
  - lw $6 followed by a flushed reader of $6: required stall=0, and e[1] loads a bubble.
- Reset mid-stall: assert reset during a load-use stall. Required: the next cycle has stall=0, ex_fwd_sel=0, stall_cnt=0.
